// File: rtl/stage_pkg.sv
// Shared encodings for the instruction stage sequencer: stages, memory
// operations, memory bus codes and the per-cycle control bundle.
package stage_pkg;

    localparam int unsigned STAGE_W   = 3;
    localparam int unsigned MEM_OP_W  = 2;
    localparam int unsigned MEM_RWZ_W = 2;

    typedef enum logic [STAGE_W-1:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_MEMORY    = 3'd4,
        ST_WRITEBACK = 3'd5
    } stage_e;

    typedef enum logic [MEM_OP_W-1:0] {
        MEM_OP_NONE  = 2'd0,
        MEM_OP_READ  = 2'd1,
        MEM_OP_WRITE = 2'd2,
        MEM_OP_WB    = 2'd3
    } mem_op_e;

    localparam logic [MEM_RWZ_W-1:0] MEM_RWZ_READ  = 2'b00;
    localparam logic [MEM_RWZ_W-1:0] MEM_RWZ_WRITE = 2'b01;
    localparam logic [MEM_RWZ_W-1:0] MEM_RWZ_HIZ   = 2'b11;

    typedef struct packed {
        logic                 ir_en;
        logic                 pc_en;
        logic                 ra_en;
        logic                 rb_en;
        logic                 rz_en;
        logic                 rm_en;
        logic                 ry_en;
        logic                 rf_write;
        logic                 ma_sel;
        logic [MEM_RWZ_W-1:0] mem_rwz;
    } ctrl_t;

    // Read and write are the only operations that wait on the memory handshake.
    function automatic logic is_mem_access(input mem_op_e op);
        return (op == MEM_OP_READ) || (op == MEM_OP_WRITE);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts MEMORY-stage wait cycles; timeout flags the last permitted wait cycle.
module mem_wait_timer
    import stage_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned TMR_W       = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic count_en,
    output logic timeout
);

    logic [TMR_W-1:0] wait_cnt;

    // Counter value N means N waits already elapsed, so the MEM_TIMEOUT-th wait sees MEM_TIMEOUT-1.
    assign timeout = (wait_cnt == TMR_W'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (clear) begin
            wait_cnt <= '0;
        end else if (count_en && !timeout) begin
            wait_cnt <= wait_cnt + TMR_W'(1);
        end
    end

endmodule

// File: rtl/stage_sequencer.sv
// Multi-cycle instruction stage sequencer: walks FETCH..WRITEBACK, decodes the
// datapath enables per stage and handles stall, flush and memory timeout.
module stage_sequencer
    import stage_pkg::*;
#(
    parameter bit          NOP_SHORTCUT = 1'b1,
    parameter int unsigned MEM_TIMEOUT  = 16,
    parameter int unsigned TMR_W        = 5,
    parameter int unsigned CNT_W        = 16
) (
    input  logic                 Clock,
    input  logic                 Reset_n,
    input  logic                 Run,
    input  logic                 Stall,
    input  logic                 Flush,
    input  logic                 NOP_FLAG,
    input  logic                 PC_Enable_Execute_Stage,
    input  logic                 MA_Select_Memory_Stage,
    input  logic [MEM_OP_W-1:0]  Mem_Op,
    input  logic                 Mem_Ready,
    output logic [STAGE_W-1:0]   Stage,
    output logic                 IR_Enable,
    output logic                 PC_Enable,
    output logic                 RA_Enable,
    output logic                 RB_Enable,
    output logic                 RZ_Enable,
    output logic                 RM_Enable,
    output logic                 RY_Enable,
    output logic                 RF_WRITE,
    output logic                 MA_Select,
    output logic [MEM_RWZ_W-1:0] MEM_r_w_z_z,
    output logic                 Instr_Done,
    output logic [CNT_W-1:0]     Instr_Count,
    output logic                 Mem_Error
);

    stage_e     state;
    stage_e     state_next;
    ctrl_t      ctrl;
    mem_op_e    mem_op;
    logic       mem_access;
    logic       mem_waiting;
    logic       in_stage;
    logic       tmr_timeout;
    logic       tmr_clear;
    logic       tmr_count_en;
    logic       timeout_evt;
    logic       retire;

    assign mem_op      = mem_op_e'(Mem_Op);
    assign mem_access  = is_mem_access(mem_op) && !NOP_FLAG;
    assign mem_waiting = mem_access && !Mem_Ready;
    assign in_stage    = (state == ST_FETCH) || (state == ST_DECODE) || (state == ST_EXECUTE)
                      || (state == ST_MEMORY) || (state == ST_WRITEBACK);

    // Timer runs only while genuinely waiting in MEMORY; leaving the stage or a flush clears it.
    assign tmr_clear    = Flush || (state != ST_MEMORY);
    assign tmr_count_en = (state == ST_MEMORY) && mem_waiting && !Stall && !Flush;

    mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .TMR_W       (TMR_W)
    ) u_mem_wait_timer (
        .clk      (Clock),
        .rst_n    (Reset_n),
        .clear    (tmr_clear),
        .count_en (tmr_count_en),
        .timeout  (tmr_timeout)
    );

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-stage and enable decode; overrides applied lowest to highest priority.
    always_comb begin
        state_next   = state;
        ctrl         = '0;
        ctrl.mem_rwz = MEM_RWZ_HIZ;
        retire       = 1'b0;
        timeout_evt  = 1'b0;

        case (state)
            ST_IDLE: begin
                ctrl.ma_sel = 1'b1;
                if (Run && !Mem_Error) state_next = ST_FETCH;
            end
            ST_FETCH: begin
                ctrl.ir_en   = 1'b1;
                ctrl.pc_en   = 1'b1;
                ctrl.ma_sel  = 1'b1;
                ctrl.mem_rwz = MEM_RWZ_READ;
                state_next   = ST_DECODE;
            end
            ST_DECODE: begin
                ctrl.ra_en = !NOP_FLAG;
                ctrl.rb_en = !NOP_FLAG;
                if (NOP_FLAG && NOP_SHORTCUT) begin
                    retire     = 1'b1;
                    state_next = Run ? ST_FETCH : ST_IDLE;
                end else begin
                    state_next = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                ctrl.rz_en = !NOP_FLAG;
                ctrl.rm_en = !NOP_FLAG;
                ctrl.pc_en = !NOP_FLAG && PC_Enable_Execute_Stage;
                state_next = ST_MEMORY;
            end
            ST_MEMORY: begin
                ctrl.ma_sel = MA_Select_Memory_Stage;
                if (mem_access) begin
                    ctrl.mem_rwz = (mem_op == MEM_OP_READ) ? MEM_RWZ_READ : MEM_RWZ_WRITE;
                end
                if (mem_waiting) begin
                    if (tmr_timeout) begin
                        timeout_evt = 1'b1;
                        state_next  = ST_IDLE;
                    end
                end else begin
                    ctrl.ry_en = !NOP_FLAG;
                    state_next = ST_WRITEBACK;
                end
            end
            ST_WRITEBACK: begin
                ctrl.ma_sel = MA_Select_Memory_Stage;
                if ((mem_op == MEM_OP_WB) && !NOP_FLAG) begin
                    ctrl.rf_write = 1'b1;
                    ctrl.mem_rwz  = MEM_RWZ_READ;
                end
                retire     = 1'b1;
                state_next = Run ? ST_FETCH : ST_IDLE;
            end
            default: begin
                ctrl.ma_sel = 1'b1;
                state_next  = ST_IDLE;
            end
        endcase

        if (Stall && in_stage) begin
            state_next    = state;
            ctrl.ir_en    = 1'b0;
            ctrl.pc_en    = 1'b0;
            ctrl.ra_en    = 1'b0;
            ctrl.rb_en    = 1'b0;
            ctrl.rz_en    = 1'b0;
            ctrl.rm_en    = 1'b0;
            ctrl.ry_en    = 1'b0;
            ctrl.rf_write = 1'b0;
            ctrl.mem_rwz  = MEM_RWZ_HIZ;
            retire        = 1'b0;
            timeout_evt   = 1'b0;
        end

        if (Flush) begin
            state_next    = Run ? ST_FETCH : ST_IDLE;
            ctrl.ir_en    = 1'b0;
            ctrl.pc_en    = 1'b0;
            ctrl.ra_en    = 1'b0;
            ctrl.rb_en    = 1'b0;
            ctrl.rz_en    = 1'b0;
            ctrl.rm_en    = 1'b0;
            ctrl.ry_en    = 1'b0;
            ctrl.rf_write = 1'b0;
            ctrl.mem_rwz  = MEM_RWZ_HIZ;
            retire        = 1'b0;
            timeout_evt   = 1'b0;
        end
    end

    // Sticky timeout flag; only a flush (or reset) releases the sequencer.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            Mem_Error <= 1'b0;
        end else if (Flush) begin
            Mem_Error <= 1'b0;
        end else if (timeout_evt) begin
            Mem_Error <= 1'b1;
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            Instr_Count <= '0;
        end else if (retire) begin
            Instr_Count <= Instr_Count + CNT_W'(1);
        end
    end

    assign Stage       = state;
    assign Instr_Done  = retire;
    assign IR_Enable   = ctrl.ir_en;
    assign PC_Enable   = ctrl.pc_en;
    assign RA_Enable   = ctrl.ra_en;
    assign RB_Enable   = ctrl.rb_en;
    assign RZ_Enable   = ctrl.rz_en;
    assign RM_Enable   = ctrl.rm_en;
    assign RY_Enable   = ctrl.ry_en;
    assign RF_WRITE    = ctrl.rf_write;
    assign MA_Select   = ctrl.ma_sel;
    assign MEM_r_w_z_z = ctrl.mem_rwz;

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed bench for stage_sequencer with hand-computed stage/enable expectations.
module tb_stage_sequencer;

    logic        Clock = 1'b0;
    logic        Reset_n;
    logic        Run, Stall, Flush, NOP_FLAG;
    logic        PC_Enable_Execute_Stage, MA_Select_Memory_Stage;
    logic [1:0]  Mem_Op;
    logic        Mem_Ready;
    logic [2:0]  Stage;
    logic        IR_Enable, PC_Enable, RA_Enable, RB_Enable, RZ_Enable, RM_Enable;
    logic        RY_Enable, RF_WRITE, MA_Select;
    logic [1:0]  MEM_r_w_z_z;
    logic        Instr_Done;
    logic [15:0] Instr_Count;
    logic        Mem_Error;

    int n_checks = 0;
    int n_errors = 0;

    stage_sequencer #(
        .NOP_SHORTCUT (1'b1),
        .MEM_TIMEOUT  (16),
        .TMR_W        (5),
        .CNT_W        (16)
    ) dut (
        .Clock                   (Clock),
        .Reset_n                 (Reset_n),
        .Run                     (Run),
        .Stall                   (Stall),
        .Flush                   (Flush),
        .NOP_FLAG                (NOP_FLAG),
        .PC_Enable_Execute_Stage (PC_Enable_Execute_Stage),
        .MA_Select_Memory_Stage  (MA_Select_Memory_Stage),
        .Mem_Op                  (Mem_Op),
        .Mem_Ready               (Mem_Ready),
        .Stage                   (Stage),
        .IR_Enable               (IR_Enable),
        .PC_Enable               (PC_Enable),
        .RA_Enable               (RA_Enable),
        .RB_Enable               (RB_Enable),
        .RZ_Enable               (RZ_Enable),
        .RM_Enable               (RM_Enable),
        .RY_Enable               (RY_Enable),
        .RF_WRITE                (RF_WRITE),
        .MA_Select               (MA_Select),
        .MEM_r_w_z_z             (MEM_r_w_z_z),
        .Instr_Done              (Instr_Done),
        .Instr_Count             (Instr_Count),
        .Mem_Error               (Mem_Error)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Advance one edge and leave 1 time unit of margin before any input change.
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    initial begin
        logic [2:0] exp_stage [6];
        int         rf_cycles;
        int         rz_seen;

        exp_stage = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd1};

        Reset_n = 1'b0; Run = 1'b0; Stall = 1'b0; Flush = 1'b0; NOP_FLAG = 1'b0;
        PC_Enable_Execute_Stage = 1'b0; MA_Select_Memory_Stage = 1'b0;
        Mem_Op = 2'd0; Mem_Ready = 1'b0;
        #12;
        check("rst_stage", 32'(Stage), 32'd0);
        check("rst_count", 32'(Instr_Count), 32'd0);
        check("rst_err", 32'(Mem_Error), 32'd0);
        check("rst_ma", 32'(MA_Select), 32'd1);
        check("rst_mem", 32'(MEM_r_w_z_z), 32'd3);
        Reset_n = 1'b1;
        tick();
        check("idle_norun", 32'(Stage), 32'd0);

        // Full five-stage instruction with register-file writeback.
        Run = 1'b1; Mem_Op = 2'd3;
        rf_cycles = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("wb_seq%0d", i), 32'(Stage), 32'(exp_stage[i]));
            rf_cycles += int'(RF_WRITE);
            if (i == 0) begin
                check("fetch_ir", 32'(IR_Enable), 32'd1);
                check("fetch_mem", 32'(MEM_r_w_z_z), 32'd0);
            end
            if (i == 3) check("mem_op3_ry", 32'(RY_Enable), 32'd1);
            if (i == 4) begin
                check("wb_mem", 32'(MEM_r_w_z_z), 32'd0);
                check("wb_done", 32'(Instr_Done), 32'd1);
            end
        end
        check("wb_rf_cycles", 32'(rf_cycles), 32'd1);
        check("wb_count", 32'(Instr_Count), 32'd1);

        // NOP shortcut: FETCH, DECODE, FETCH with no register enables.
        NOP_FLAG = 1'b1;
        rz_seen = 0;
        tick();
        check("nop_decode", 32'(Stage), 32'd2);
        check("nop_ra", 32'(RA_Enable), 32'd0);
        check("nop_rb", 32'(RB_Enable), 32'd0);
        check("nop_done", 32'(Instr_Done), 32'd1);
        rz_seen += int'(RZ_Enable);
        tick();
        rz_seen += int'(RZ_Enable);
        check("nop_back_fetch", 32'(Stage), 32'd1);
        check("nop_rz", 32'(rz_seen), 32'd0);
        check("nop_count", 32'(Instr_Count), 32'd2);
        NOP_FLAG = 1'b0;

        // Read with Mem_Ready arriving in the fourth MEMORY cycle.
        Mem_Op = 2'd1;
        tick(); tick(); tick();
        for (int c = 1; c <= 4; c++) begin
            if (c == 4) Mem_Ready = 1'b1;
            #1;
            check($sformatf("rd_stage_c%0d", c), 32'(Stage), 32'd4);
            check($sformatf("rd_mem_c%0d", c), 32'(MEM_r_w_z_z), 32'd0);
            check($sformatf("rd_ry_c%0d", c), 32'(RY_Enable), (c == 4) ? 32'd1 : 32'd0);
            tick();
        end
        Mem_Ready = 1'b0;
        #1;
        check("rd_wb_stage", 32'(Stage), 32'd5);
        check("rd_wb_mem", 32'(MEM_r_w_z_z), 32'd3);
        check("rd_wb_rf", 32'(RF_WRITE), 32'd0);
        tick();
        check("rd_count", 32'(Instr_Count), 32'd3);

        // Write that never completes: timeout after 16 MEMORY cycles.
        Mem_Op = 2'd2;
        tick(); tick(); tick();
        check("to_enter_mem", 32'(Stage), 32'd4);
        check("to_mem_code", 32'(MEM_r_w_z_z), 32'd1);
        for (int c = 1; c <= 16; c++) begin
            if (c == 16) check("to_last_wait_stage", 32'(Stage), 32'd4);
            check($sformatf("to_err_c%0d", c), 32'(Mem_Error), 32'd0);
            tick();
        end
        check("to_stage_idle", 32'(Stage), 32'd0);
        check("to_err_set", 32'(Mem_Error), 32'd1);
        tick(); tick(); tick();
        check("to_run_ignored", 32'(Stage), 32'd0);
        Flush = 1'b1;
        tick();
        Flush = 1'b0;
        #1;
        check("to_flush_fetch", 32'(Stage), 32'd1);
        check("to_flush_clr", 32'(Mem_Error), 32'd0);
        check("to_no_retire", 32'(Instr_Count), 32'd3);

        // Flush in EXECUTE aborts without retiring.
        Mem_Op = 2'd3;
        tick(); tick();
        Flush = 1'b1;
        #1;
        check("fl_rz_off", 32'(RZ_Enable), 32'd0);
        tick();
        Flush = 1'b0;
        #1;
        check("fl_fetch", 32'(Stage), 32'd1);
        check("fl_count", 32'(Instr_Count), 32'd3);

        // Two stall cycles in EXECUTE, then reset in WRITEBACK.
        tick(); tick();
        Stall = 1'b1;
        #1;
        check("st_c1_stage", 32'(Stage), 32'd3);
        check("st_c1_rz", 32'(RZ_Enable), 32'd0);
        check("st_c1_mem", 32'(MEM_r_w_z_z), 32'd3);
        tick();
        check("st_c2_stage", 32'(Stage), 32'd3);
        check("st_c2_rz", 32'(RZ_Enable), 32'd0);
        Stall = 1'b0;
        #1;
        check("st_release_rz", 32'(RZ_Enable), 32'd1);
        tick(); tick();
        check("st_wb_stage", 32'(Stage), 32'd5);
        check("st_wb_rf", 32'(RF_WRITE), 32'd1);
        Reset_n = 1'b0;
        #1;
        check("rst_mid_stage", 32'(Stage), 32'd0);
        check("rst_mid_count", 32'(Instr_Count), 32'd0);
        check("rst_mid_rf", 32'(RF_WRITE), 32'd0);
        check("rst_mid_mem", 32'(MEM_r_w_z_z), 32'd3);
        Run = 1'b0;
        #3;
        Reset_n = 1'b1;
        tick();
        check("post_rst_idle", 32'(Stage), 32'd0);
        Run = 1'b1;
        tick();
        check("post_rst_fetch", 32'(Stage), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end

endmodule

// File: doc/stage_sequencer.md
STAGE_SEQUENCER -- requirements
Module: stage_sequencer

Interface
REQ-001 SHALL have parameter NOP_SHORTCUT, 1, when 1 a NOP returns to FETCH after DECODE; when 0 it runs all five stages with datapath enables off.
REQ-002 SHALL have parameter MEM_TIMEOUT, 16, the maximum number of MEMORY-stage cycles spent waiting for Mem_Ready (range 1..2^TMR_W-1).
REQ-003 SHALL have parameter TMR_W, 5, the width of the wait-timer.
REQ-004 SHALL have parameter CNT_W, 16, the width of the retired-instruction counter.
REQ-005 SHALL have a single clock and an asynchronous, active-low reset: Clock  in  1  rising-edge clock; Reset_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have the control inputs: Run  in  1  permits fetch of a new instruction; Stall  in  1  holds the current stage; Flush  in  1  aborts the current instruction.
REQ-007 SHALL have the instruction-decode inputs: NOP_FLAG  in  1  current instruction is a NOP; PC_Enable_Execute_Stage  in  1  branch reload of PC in EXECUTE; MA_Select_Memory_Stage  in  1  memory-address mux select in MEMORY/WRITEBACK.
REQ-008 SHALL have the memory inputs: Mem_Op  in  2  operation, encoded 0 none, 1 read, 2 write, 3 register-file writeback; Mem_Ready  in  1  memory completion handshake.
REQ-009 SHALL have the stage outputs: Stage  out  3  current stage, encoded 0 IDLE, 1 FETCH, 2 DECODE, 3 EXECUTE, 4 MEMORY, 5 WRITEBACK.
REQ-010 SHALL have the enable outputs IR_Enable, PC_Enable, RA_Enable, RB_Enable, RZ_Enable, RM_Enable, RY_Enable, RF_WRITE and MA_Select (out, 1 bit each), and MEM_r_w_z_z (out, 2 bits: 00 read, 01 write, 11 high impedance).
REQ-011 SHALL have the status outputs: Instr_Done  out  1  one-cycle retire pulse; Instr_Count  out  CNT_W  retired-instruction count; Mem_Error  out  1  sticky MEMORY-stage timeout flag.

Function
REQ-012 SHALL register Stage; all enable outputs SHALL be a combinational decode of Stage, Stall, Mem_Ready and the instruction-decode inputs.
REQ-013 SHALL apply the transitions IDLE->FETCH when Run=1 and Mem_Error=0, then FETCH->DECODE->EXECUTE->MEMORY->WRITEBACK, then WRITEBACK->FETCH if Run=1, else WRITEBACK->IDLE.
REQ-014 SHALL apply, when NOP_FLAG=1 in DECODE and NOP_SHORTCUT=1, the transition DECODE->FETCH (or DECODE->IDLE if Run=0), retiring the NOP.
REQ-015 SHALL decode FETCH as IR_Enable=1, PC_Enable=1, MA_Select=1 and MEM_r_w_z_z=00.
REQ-016 SHALL decode DECODE as RA_Enable=1 and RB_Enable=1 when NOP_FLAG=0, with MEM_r_w_z_z=11.
REQ-017 SHALL decode EXECUTE as RZ_Enable=1, RM_Enable=1 and PC_Enable=PC_Enable_Execute_Stage when NOP_FLAG=0, with MEM_r_w_z_z=11.
REQ-018 SHALL decode MEMORY as MA_Select=MA_Select_Memory_Stage with MEM_r_w_z_z=00 for Mem_Op 1, 01 for Mem_Op 2 and 11 otherwise; RY_Enable=1 only in the exit cycle.
REQ-019 SHALL decode WRITEBACK as RF_WRITE=1 and MEM_r_w_z_z=00 when Mem_Op=3, else MEM_r_w_z_z=11.
REQ-020 SHALL decode IDLE as all enables 0, MA_Select=1 and MEM_r_w_z_z=11.
REQ-021 SHALL hold MEMORY while Mem_Op is 1 or 2 and Mem_Ready=0, and SHALL exit MEMORY on the first cycle Mem_Ready=1; Mem_Op 0 or 3 SHALL exit after one cycle.
REQ-022 SHALL count MEMORY wait cycles; when the count reaches MEM_TIMEOUT without Mem_Ready, it SHALL set Mem_Error, force RY_Enable=0, and move to IDLE.
REQ-023 SHALL freeze Stage and the wait timer while Stall=1 in any non-IDLE stage, forcing all register enables and RF_WRITE to 0 and MEM_r_w_z_z to 11.
REQ-024 SHALL, on Flush=1, force all enables to 0 in that cycle, load FETCH (or IDLE if Run=0), clear Mem_Error and the wait timer, and not retire the instruction.
REQ-025 SHALL apply the priority Flush > Stall > timeout > Mem_Ready > normal advance.
REQ-026 SHALL pulse Instr_Done in the final WRITEBACK cycle, or in the shortcut DECODE cycle, and SHALL increment Instr_Count in the same edge, wrapping at 2^CNT_W-1 -> 0.
REQ-027 SHALL decode any unused Stage encoding (6, 7) as IDLE outputs and return to IDLE on the next edge.

Reset
REQ-028 SHALL, on Reset_n=0, immediately set Stage=IDLE, wait timer=0, Instr_Count=0 and Mem_Error=0, forcing the IDLE outputs, including mid-instruction.
REQ-029 SHALL, after Reset_n rises, require one edge with Run=1 before reaching FETCH.

Structure
REQ-030 SHALL place the stage encodings, Mem_Op encodings and MEM_r_w_z_z codes in the shared package stage_pkg.
REQ-031 SHALL implement the wait timer and timeout compare as the sub-module mem_wait_timer (ports: clear, count-enable, timeout).

Verification
REQ-032 SHALL cover: Run=1, Mem_Op=3, no stall -> Stage 1,2,3,4,5,1; RF_WRITE high one cycle; Instr_Count=1 after 5 cycles.
REQ-033 SHALL cover: NOP_FLAG=1 with NOP_SHORTCUT=1 -> Stage 1,2,1; no RA/RB/RZ enables; Instr_Done at cycle 2.
REQ-034 SHALL cover: Mem_Op=1 with Mem_Ready delayed 3 cycles -> MEMORY held 4 cycles; MEM_r_w_z_z=00 throughout; RY_Enable only in the 4th cycle.
REQ-035 SHALL cover: Mem_Op=2, Mem_Ready=0, MEM_TIMEOUT=16 -> Mem_Error=1 after 16 MEMORY cycles; Stage=0; Run=1 ignored until Flush.
REQ-036 SHALL cover: Stall=1 for 2 cycles in EXECUTE, then Reset_n=0 mid-WRITEBACK -> Stage held at 3 with RZ_Enable=0; immediate IDLE with Instr_Count=0.
